// File: rtl/conf_cmd_ctrl_pkg.sv
// Shared definitions for the configuration command sequencer: default widths,
// register count, dump command byte and the sequencer state encoding.
`timescale 1ns/1ps
package conf_cmd_ctrl_pkg;

  localparam int              CONF_ADDR_WIDTH     = 8;
  localparam int              CONF_DATA_WIDTH     = 8;
  localparam int              CONF_TX_WIDTH       = 8;
  localparam int              CONF_NUM_REGS       = 16;
  localparam logic [7:0]      CONF_DUMP_CMD       = 8'hFF;
  localparam int              CONF_TIMEOUT_CYCLES = 1000000;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_DATA  = 3'd1,
    WRITE      = 3'd2,
    DUMP_REQ   = 3'd3,
    DUMP_SEND  = 3'd4,
    DUMP_SHIFT = 3'd5,
    DUMP_WAIT  = 3'd6
  } cmd_state_t;

  // Counter width able to hold values up to n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conf_cmd_timeout.sv
// Inter-byte timeout counter: clears while disabled, counts while enabled and
// saturates at TIMEOUT_CYCLES-1, which is flagged as the terminal count.
`timescale 1ns/1ps
module conf_cmd_timeout
  import conf_cmd_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = CONF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int            CW   = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !terminal) begin
      count <= count + CW'(1);
    end
  end

  assign terminal = (count == LAST);

endmodule

// File: rtl/conf_cmd_ctrl.sv
// Byte command sequencer: turns UART (address, data) pairs into register write
// handshakes and streams a snapshot of all registers back on a dump command.
`timescale 1ns/1ps
module conf_cmd_ctrl
  import conf_cmd_ctrl_pkg::*;
#(
  parameter int                   ADDR_WIDTH     = CONF_ADDR_WIDTH,
  parameter int                   DATA_WIDTH     = CONF_DATA_WIDTH,
  parameter int                   TX_WIDTH       = CONF_TX_WIDTH,
  parameter int                   NUM_REGS       = CONF_NUM_REGS,
  parameter logic [DATA_WIDTH-1:0] DUMP_CMD      = DATA_WIDTH'(CONF_DUMP_CMD),
  parameter int                   TIMEOUT_CYCLES = CONF_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_rdy,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_start,
  input  logic                  tx_busy,
  output logic [ADDR_WIDTH-1:0] register_addr,
  output logic [DATA_WIDTH-1:0] register_data,
  output logic                  register_rdy,
  input  logic                  register_ack,
  output logic                  sr_request,
  output logic                  sr_ack,
  input  logic [TX_WIDTH-1:0]   sr_data,
  input  logic                  sr_empty,
  output logic                  frame_err,
  output logic                  rx_overrun
);

  localparam logic [31:0] NUM_REGS_U = 32'(NUM_REGS);

  cmd_state_t state, next_state;

  logic is_dump, addr_ok, timeout_hit;
  logic load_addr, load_data;
  logic tx_start_d, sr_request_d, sr_ack_d, frame_err_d, rx_overrun_d, register_rdy_d;

  assign is_dump = (rx_data == DUMP_CMD);
  assign addr_ok = (32'(rx_data) < NUM_REGS_U);

  // Counter only runs while an address is waiting for its data byte.
  conf_cmd_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (state != WAIT_DATA),
    .enable  ((state == WAIT_DATA) && !rx_rdy),
    .terminal(timeout_hit)
  );

  // All outputs are registered so pulses line up with the state they belong to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      tx_data       <= '0;
      tx_start      <= 1'b0;
      register_addr <= '0;
      register_data <= '0;
      register_rdy  <= 1'b0;
      sr_request    <= 1'b0;
      sr_ack        <= 1'b0;
      frame_err     <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      state        <= next_state;
      tx_start     <= tx_start_d;
      register_rdy <= register_rdy_d;
      sr_request   <= sr_request_d;
      sr_ack       <= sr_ack_d;
      frame_err    <= frame_err_d;
      rx_overrun   <= rx_overrun_d;
      if (load_addr)  register_addr <= ADDR_WIDTH'(rx_data);
      if (load_data)  register_data <= rx_data;
      if (tx_start_d) tx_data       <= DATA_WIDTH'(sr_data);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (rx_rdy) begin
          if (is_dump)      next_state = DUMP_REQ;
          else if (addr_ok) next_state = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (rx_rdy)           next_state = WRITE;
        else if (timeout_hit) next_state = IDLE;
      end
      WRITE:      if (register_ack) next_state = IDLE;
      DUMP_REQ:   next_state = DUMP_SEND;
      DUMP_SEND: begin
        if (sr_empty)      next_state = IDLE;
        else if (!tx_busy) next_state = DUMP_SHIFT;
      end
      DUMP_SHIFT: next_state = DUMP_WAIT;
      DUMP_WAIT:  next_state = DUMP_SEND;
      default:    next_state = IDLE;
    endcase
  end

  // A data byte arriving on the terminal timeout cycle still counts as data.
  always_comb begin
    load_addr    = 1'b0;
    load_data    = 1'b0;
    frame_err_d  = 1'b0;
    rx_overrun_d = 1'b0;
    case (state)
      IDLE: begin
        if (rx_rdy && !is_dump) begin
          if (addr_ok) load_addr   = 1'b1;
          else         frame_err_d = 1'b1;
        end
      end
      WAIT_DATA: begin
        if (rx_rdy)           load_data   = 1'b1;
        else if (timeout_hit) frame_err_d = 1'b1;
      end
      default: rx_overrun_d = rx_rdy;
    endcase
    register_rdy_d = (next_state == WRITE);
    sr_request_d   = (next_state == DUMP_REQ);
    tx_start_d     = (next_state == DUMP_SHIFT);
    sr_ack_d       = (next_state == DUMP_WAIT);
  end

endmodule

// File: tb/tb_conf_cmd_ctrl.sv
// Directed bench for conf_cmd_ctrl with small models of conf_regs, the
// configuration shift register and a UART transmitter that stays busy 10 cycles.
`timescale 1ns/1ps
module tb_conf_cmd_ctrl;
  import conf_cmd_ctrl_pkg::*;

  localparam int NREGS = 4;
  localparam int TMO   = 50;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_rdy = 1'b0;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic [7:0] register_addr;
  logic [7:0] register_data;
  logic       register_rdy;
  logic       register_ack = 1'b0;
  logic       sr_request;
  logic       sr_ack;
  logic [7:0] sr_data;
  logic       sr_empty;
  logic       frame_err;
  logic       rx_overrun;

  logic hold_ack = 1'b0;
  logic reload_mem = 1'b0;
  int   n_compared = 0;
  int   n_mismatched = 0;

  conf_cmd_ctrl #(
    .ADDR_WIDTH(8), .DATA_WIDTH(8), .TX_WIDTH(8), .NUM_REGS(NREGS),
    .DUMP_CMD(8'hFF), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_rdy(rx_rdy),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .register_addr(register_addr), .register_data(register_data),
    .register_rdy(register_rdy), .register_ack(register_ack),
    .sr_request(sr_request), .sr_ack(sr_ack), .sr_data(sr_data),
    .sr_empty(sr_empty), .frame_err(frame_err), .rx_overrun(rx_overrun)
  );

  always #5 clk = ~clk;

  // conf_regs model: acknowledges a write two cycles after register_rdy rises.
  logic [7:0] mem [0:NREGS-1];
  int ack_age = 0;
  always @(posedge clk) begin
    if (reload_mem) begin
      mem[0] <= 8'h11; mem[1] <= 8'h22; mem[2] <= 8'h33; mem[3] <= 8'h44;
    end
    register_ack <= 1'b0;
    if (register_rdy && !register_ack && !hold_ack) begin
      if (ack_age == 1) begin
        register_ack <= 1'b1;
        ack_age <= 0;
        if (register_addr < NREGS) mem[register_addr[1:0]] <= register_data;
      end else begin
        ack_age <= ack_age + 1;
      end
    end else if (!register_rdy) begin
      ack_age <= 0;
    end
  end

  // Shift register model: snapshot on sr_request, lowest word first.
  logic [7:0] sr_words [0:NREGS-1];
  int sr_cnt = 0;
  always @(posedge clk) begin
    if (sr_request) begin
      for (int i = 0; i < NREGS; i++) sr_words[i] <= mem[i];
      sr_cnt <= NREGS;
    end else if (sr_ack && sr_cnt > 0) begin
      for (int i = 0; i < NREGS - 1; i++) sr_words[i] <= sr_words[i+1];
      sr_words[NREGS-1] <= 8'h00;
      sr_cnt <= sr_cnt - 1;
    end
  end
  assign sr_data  = sr_words[0];
  assign sr_empty = (sr_cnt == 0);

  int busy_cnt = 0;
  always @(posedge clk) begin
    if (tx_start)          busy_cnt <= 10;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  // Event recorder; tasks compare against snapshots of these counters.
  logic [7:0] cap [0:63];
  int cap_n = 0, busy_viol = 0, ovr_n = 0, ferr_n = 0, req_n = 0, sack_n = 0, dbl_n = 0, rdy_n = 0;
  logic [4:0] prev_p = 5'b0;
  always @(posedge clk) begin
    if (tx_start) begin
      if (cap_n < 64) cap[cap_n] <= tx_data;
      cap_n <= cap_n + 1;
      if (tx_busy) busy_viol <= busy_viol + 1;
    end
    if (rx_overrun)   ovr_n  <= ovr_n + 1;
    if (frame_err)    ferr_n <= ferr_n + 1;
    if (sr_request)   req_n  <= req_n + 1;
    if (sr_ack)       sack_n <= sack_n + 1;
    if (register_rdy) rdy_n  <= rdy_n + 1;
    if (|({tx_start, sr_request, sr_ack, frame_err, rx_overrun} & prev_p)) dbl_n <= dbl_n + 1;
    prev_p <= {tx_start, sr_request, sr_ack, frame_err, rx_overrun};
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_rdy  = 1'b1;
    @(negedge clk);
    rx_rdy  = 1'b0;
  endtask

  task automatic wait_ack(output int cycles);
    cycles = 0;
    while (register_ack !== 1'b1 && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    @(negedge clk);
  endtask

  task automatic reload_regs();
    @(negedge clk); reload_mem = 1'b1;
    @(negedge clk); reload_mem = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_compared++; if ({tx_start, sr_request, sr_ack, frame_err, rx_overrun, register_rdy} !== 6'b0) begin n_mismatched++; $display("[TB] FAIL reset_pulses: got %b expected 000000", {tx_start, sr_request, sr_ack, frame_err, rx_overrun, register_rdy}); end
    n_compared++; if ({tx_data, register_addr, register_data} !== 24'h0) begin n_mismatched++; $display("[TB] FAIL reset_data: got %h expected 000000", {tx_data, register_addr, register_data}); end
    n_compared++; if (dut.state !== IDLE) begin n_mismatched++; $display("[TB] FAIL reset_state: got %0d expected %0d", dut.state, IDLE); end
    rst = 1'b1;
    reload_regs();
  endtask

  task automatic test_write();
    int cyc;
    logic unstable;
    send_byte(8'h03);
    send_byte(8'hA5);
    n_compared++; if (register_rdy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL write_rdy_latency: got %b expected 1", register_rdy); end
    n_compared++; if (register_addr !== 8'h03) begin n_mismatched++; $display("[TB] FAIL write_addr: got %h expected 03", register_addr); end
    n_compared++; if (register_data !== 8'hA5) begin n_mismatched++; $display("[TB] FAIL write_data: got %h expected a5", register_data); end
    unstable = 1'b0;
    for (cyc = 0; cyc < 20 && register_ack !== 1'b1; cyc++) begin
      @(negedge clk);
      if (register_rdy !== 1'b1 || register_addr !== 8'h03 || register_data !== 8'hA5) unstable = 1'b1;
    end
    n_compared++; if (cyc !== 2) begin n_mismatched++; $display("[TB] FAIL write_ack_cycle: got %0d expected 2", cyc); end
    n_compared++; if (unstable !== 1'b0) begin n_mismatched++; $display("[TB] FAIL write_hold_stable: got %b expected 0", unstable); end
    @(negedge clk);
    n_compared++; if (register_rdy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL write_rdy_drop: got %b expected 0", register_rdy); end
    n_compared++; if (dut.state !== IDLE) begin n_mismatched++; $display("[TB] FAIL write_idle: got %0d expected %0d", dut.state, IDLE); end
    n_compared++; if (mem[3] !== 8'hA5) begin n_mismatched++; $display("[TB] FAIL write_mem3: got %h expected a5", mem[3]); end
    begin
      int q0;
      q0 = req_n;
      send_byte(8'h01);
      send_byte(8'hFF);
      n_compared++; if ({register_rdy, register_data} !== {1'b1, 8'hFF}) begin n_mismatched++; $display("[TB] FAIL write_dumpcmd_as_data: got %h expected 1ff", {register_rdy, register_data}); end
      wait_ack(cyc);
      n_compared++; if (mem[1] !== 8'hFF) begin n_mismatched++; $display("[TB] FAIL write_mem1: got %h expected ff", mem[1]); end
      n_compared++; if (req_n - q0 !== 0) begin n_mismatched++; $display("[TB] FAIL write_no_dump: got %0d expected 0", req_n - q0); end
    end
  endtask

  task automatic test_invalid();
    int f0, r0;
    f0 = ferr_n; r0 = rdy_n;
    send_byte(8'h20);
    n_compared++; if (frame_err !== 1'b1) begin n_mismatched++; $display("[TB] FAIL invalid_ferr: got %b expected 1", frame_err); end
    @(negedge clk);
    n_compared++; if (frame_err !== 1'b0) begin n_mismatched++; $display("[TB] FAIL invalid_ferr_pulse: got %b expected 0", frame_err); end
    send_byte(8'h04);
    n_compared++; if (frame_err !== 1'b1) begin n_mismatched++; $display("[TB] FAIL invalid_boundary: got %b expected 1", frame_err); end
    repeat (3) @(negedge clk);
    n_compared++; if (ferr_n - f0 !== 2) begin n_mismatched++; $display("[TB] FAIL invalid_ferr_count: got %0d expected 2", ferr_n - f0); end
    n_compared++; if (rdy_n - r0 !== 0) begin n_mismatched++; $display("[TB] FAIL invalid_no_rdy: got %0d expected 0", rdy_n - r0); end
    n_compared++; if (dut.state !== IDLE) begin n_mismatched++; $display("[TB] FAIL invalid_idle: got %0d expected %0d", dut.state, IDLE); end
  endtask

  task automatic test_timeout();
    int k, cyc;
    send_byte(8'h01);
    for (k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (frame_err === 1'b1) break;
    end
    n_compared++; if (k !== TMO) begin n_mismatched++; $display("[TB] FAIL timeout_cycle: got %0d expected %0d", k, TMO); end
    n_compared++; if (dut.state !== IDLE) begin n_mismatched++; $display("[TB] FAIL timeout_idle: got %0d expected %0d", dut.state, IDLE); end
    send_byte(8'h02);
    send_byte(8'h7E);
    wait_ack(cyc);
    n_compared++; if (cyc >= 20) begin n_mismatched++; $display("[TB] FAIL timeout_next_write_ack: got %0d cycles expected under 20", cyc); end
    n_compared++; if (mem[2] !== 8'h7E) begin n_mismatched++; $display("[TB] FAIL timeout_next_write: got %h expected 7e", mem[2]); end
    send_byte(8'h01);
    repeat (TMO - 2) @(negedge clk);
    send_byte(8'h5C);
    n_compared++; if ({register_rdy, frame_err} !== 2'b10) begin n_mismatched++; $display("[TB] FAIL timeout_terminal_data: got %b expected 10", {register_rdy, frame_err}); end
    wait_ack(cyc);
    n_compared++; if (mem[1] !== 8'h5C) begin n_mismatched++; $display("[TB] FAIL timeout_terminal_mem: got %h expected 5c", mem[1]); end
  endtask

  task automatic test_dump();
    int c0, v0, q0, a0;
    logic [7:0] exp_b [0:3];
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;
    reload_regs();
    c0 = cap_n; v0 = busy_viol; q0 = req_n; a0 = sack_n;
    send_byte(8'hFF);
    n_compared++; if (sr_request !== 1'b1) begin n_mismatched++; $display("[TB] FAIL dump_request: got %b expected 1", sr_request); end
    repeat (80) @(negedge clk);
    n_compared++; if (cap_n - c0 !== 4) begin n_mismatched++; $display("[TB] FAIL dump_count: got %0d expected 4", cap_n - c0); end
    for (int i = 0; i < 4; i++) begin
      n_compared++; if (cap[c0+i] !== exp_b[i]) begin n_mismatched++; $display("[TB] FAIL dump_byte%0d: got %h expected %h", i, cap[c0+i], exp_b[i]); end
    end
    n_compared++; if (busy_viol - v0 !== 0) begin n_mismatched++; $display("[TB] FAIL dump_start_while_busy: got %0d expected 0", busy_viol - v0); end
    n_compared++; if ({req_n - q0, sack_n - a0} !== {32'd1, 32'd4}) begin n_mismatched++; $display("[TB] FAIL dump_sr_pulses: got req %0d ack %0d expected req 1 ack 4", req_n - q0, sack_n - a0); end
    n_compared++; if (dut.state !== IDLE) begin n_mismatched++; $display("[TB] FAIL dump_idle: got %0d expected %0d", dut.state, IDLE); end
  endtask

  task automatic test_overrun();
    int c0, o0, q0, cyc;
    logic [7:0] exp_b [0:3];
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;
    reload_regs();
    c0 = cap_n; o0 = ovr_n;
    send_byte(8'hFF);
    repeat (3) @(negedge clk);
    send_byte(8'h02);
    n_compared++; if (rx_overrun !== 1'b1) begin n_mismatched++; $display("[TB] FAIL overrun_dump_a: got %b expected 1", rx_overrun); end
    repeat (12) @(negedge clk);
    send_byte(8'h55);
    n_compared++; if (rx_overrun !== 1'b1) begin n_mismatched++; $display("[TB] FAIL overrun_dump_b: got %b expected 1", rx_overrun); end
    repeat (80) @(negedge clk);
    n_compared++; if (cap_n - c0 !== 4) begin n_mismatched++; $display("[TB] FAIL overrun_dump_count: got %0d expected 4", cap_n - c0); end
    for (int i = 0; i < 4; i++) begin
      n_compared++; if (cap[c0+i] !== exp_b[i]) begin n_mismatched++; $display("[TB] FAIL overrun_dump_byte%0d: got %h expected %h", i, cap[c0+i], exp_b[i]); end
    end
    n_compared++; if (ovr_n - o0 !== 2) begin n_mismatched++; $display("[TB] FAIL overrun_dump_pulses: got %0d expected 2", ovr_n - o0); end
    o0 = ovr_n; q0 = req_n;
    hold_ack = 1'b1;
    send_byte(8'h02);
    send_byte(8'h9C);
    send_byte(8'h03);
    n_compared++; if (rx_overrun !== 1'b1) begin n_mismatched++; $display("[TB] FAIL overrun_write_a: got %b expected 1", rx_overrun); end
    send_byte(8'hFF);
    repeat (5) @(negedge clk);
    n_compared++; if ({register_rdy, register_addr, register_data} !== {1'b1, 8'h02, 8'h9C}) begin n_mismatched++; $display("[TB] FAIL overrun_write_hold: got %h expected 1029c", {register_rdy, register_addr, register_data}); end
    hold_ack = 1'b0;
    wait_ack(cyc);
    n_compared++; if (mem[2] !== 8'h9C) begin n_mismatched++; $display("[TB] FAIL overrun_write_mem: got %h expected 9c", mem[2]); end
    n_compared++; if ({ovr_n - o0, req_n - q0} !== {32'd2, 32'd0}) begin n_mismatched++; $display("[TB] FAIL overrun_write_pulses: got ovr %0d req %0d expected ovr 2 req 0", ovr_n - o0, req_n - q0); end
  endtask

  task automatic test_reset_mid_dump();
    int n, c0;
    logic [7:0] exp_b [0:3];
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;
    reload_regs();
    send_byte(8'hFF);
    n = 0;
    for (int cyc = 0; cyc < 100 && n < 2; cyc++) begin
      @(negedge clk);
      if (tx_start === 1'b1) n++;
    end
    n_compared++; if (n !== 2) begin n_mismatched++; $display("[TB] FAIL rstdump_second_start: got %0d expected 2", n); end
    n_compared++; if (tx_data !== 8'h22) begin n_mismatched++; $display("[TB] FAIL rstdump_second_byte: got %h expected 22", tx_data); end
    #1 rst = 1'b0;
    #1;
    n_compared++; if ({tx_start, sr_request, sr_ack, frame_err, rx_overrun, register_rdy} !== 6'b0) begin n_mismatched++; $display("[TB] FAIL rstdump_async_pulses: got %b expected 000000", {tx_start, sr_request, sr_ack, frame_err, rx_overrun, register_rdy}); end
    n_compared++; if ({tx_data, register_addr, register_data} !== 24'h0) begin n_mismatched++; $display("[TB] FAIL rstdump_async_data: got %h expected 000000", {tx_data, register_addr, register_data}); end
    n_compared++; if (dut.state !== IDLE) begin n_mismatched++; $display("[TB] FAIL rstdump_state: got %0d expected %0d", dut.state, IDLE); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    c0 = cap_n;
    send_byte(8'hFF);
    repeat (80) @(negedge clk);
    n_compared++; if (cap_n - c0 !== 4) begin n_mismatched++; $display("[TB] FAIL rstdump_redump_count: got %0d expected 4", cap_n - c0); end
    for (int i = 0; i < 4; i++) begin
      n_compared++; if (cap[c0+i] !== exp_b[i]) begin n_mismatched++; $display("[TB] FAIL rstdump_redump_byte%0d: got %h expected %h", i, cap[c0+i], exp_b[i]); end
    end
  endtask

  task automatic test_pulse_width();
    n_compared++; if (dbl_n !== 0) begin n_mismatched++; $display("[TB] FAIL pulse_width: got %0d double-wide pulses expected 0", dbl_n); end
  endtask

  initial begin
    $display("[TB] conf_cmd_ctrl bench start");
    test_reset();
    test_write();
    test_invalid();
    test_timeout();
    test_dump();
    test_overrun();
    test_reset_mid_dump();
    test_pulse_width();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion expected finish before 200000ns");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/conf_cmd_ctrl.md
Name: conf_cmd_ctrl

Overview:
- Byte-level command sequencer between the UART byte interfaces and the configuration register block.
- Parses incoming (address, data) byte pairs and drives the register write handshake (register_addr/register_data/register_rdy/register_ack).
- On a dump command, sequences the configuration shift register (request/ack/empty) and streams every register byte back through the UART transmitter.

Parameters:
ADDR_WIDTH, 8, register address width; equals the conf_regs address width
DATA_WIDTH, 8, register data width; equals UART byte width
TX_WIDTH, 8, shift register output width; must equal DATA_WIDTH
NUM_REGS, 16, number of implemented registers; addresses >= NUM_REGS are rejected
DUMP_CMD, 8'hFF, address byte value that triggers a full read-back
TIMEOUT_CYCLES, 1000000, max clk cycles allowed between address byte and data byte

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
rx_data  in  DATA_WIDTH  byte from UART receiver
rx_rdy  in  1  one-cycle strobe, rx_data valid
tx_data  out  DATA_WIDTH  byte to UART transmitter
tx_start  out  1  one-cycle strobe, start transmitting tx_data
tx_busy  in  1  UART transmitter busy; rises the cycle after tx_start
register_addr  out  ADDR_WIDTH  write address to conf_regs
register_data  out  DATA_WIDTH  write data to conf_regs
register_rdy  out  1  write request, held until register_ack
register_ack  in  1  write accepted by conf_regs
sr_request  out  1  one-cycle pulse: load register array into shift register
sr_ack  out  1  one-cycle pulse: shift by TX_WIDTH
sr_data  in  TX_WIDTH  lowest word of shift register
sr_empty  in  1  all words shifted out
frame_err  out  1  one-cycle pulse: timeout or invalid address
rx_overrun  out  1  one-cycle pulse: byte received while busy, byte discarded

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; all outputs 0; timeout counter 0.
- IDLE: on rx_rdy:
  - rx_data==DUMP_CMD -> DUMP_REQ.
  - rx_data<NUM_REGS -> latch into register_addr, clear timeout counter -> WAIT_DATA.
  - Otherwise pulse frame_err, stay in IDLE.
- WAIT_DATA: on rx_rdy, latch register_data -> WRITE; register_rdy=1 from the next cycle. Counter increments each cycle without rx_rdy. When it reaches TIMEOUT_CYCLES-1, pulse frame_err -> IDLE. rx_rdy on the terminal cycle wins over the timeout. The data byte may equal DUMP_CMD; it is treated as data.
- WRITE: register_rdy held high, register_addr/register_data held stable. In the cycle register_ack is sampled high, register_rdy is cleared -> IDLE. Minimum write latency: data byte to register_rdy, 1 cycle. There is no write timeout.
- DUMP_REQ: sr_request=1 for exactly one cycle -> DUMP_SEND.
- DUMP_SEND:
  - sr_empty=1 -> IDLE.
  - Else if tx_busy=0: tx_data=sr_data, tx_start=1 for one cycle -> DUMP_SHIFT.
  - Else wait.
- DUMP_SHIFT: sr_ack=1 for one cycle -> DUMP_WAIT.
- DUMP_WAIT: wait one cycle so that tx_busy is valid -> DUMP_SEND. DUMP_SEND then blocks until the transmitter is idle.
- Byte count: exactly NUM_REGS bytes are transmitted, register 0 first (lowest word first).
- rx_rdy in WRITE, DUMP_*: byte discarded, rx_overrun pulsed the same cycle, state unaffected.
- Register contents changed during a dump are not reflected; the snapshot is taken at sr_request.
- Outputs tx_start, sr_request, sr_ack, frame_err and rx_overrun are registered pulses, never high for 2 consecutive cycles.
- rst asserted mid-write or mid-dump: immediate return to IDLE, register_rdy dropped. A partially sent dump is not resumed.

Decomposition:
- Shared defines file (alongside the conf_regs defines): ADDR/DATA/TX widths, NUM_REGS, DUMP_CMD, and the state encodings (IDLE, WAIT_DATA, WRITE, DUMP_REQ, DUMP_SEND, DUMP_SHIFT, DUMP_WAIT) as localparams.
- One natural sub-module, conf_cmd_timeout: loadable/clearable counter with terminal-count flag, parameterised by TIMEOUT_CYCLES.
- Everything else is a single FSM in conf_cmd_ctrl.

Test Plan:
1. Write: rx 8'h03 then 8'hA5; conf_regs model acks 2 cycles after register_rdy -> register_addr=3, register_data=A5 held stable; register_rdy falls the cycle after register_ack; back in IDLE.
2. Dump: NUM_REGS=4 with model contents {11,22,33,44}; rx 8'hFF; tx_busy model busy 10 cycles per byte -> exactly 4 tx_start pulses carrying 11,22,33,44 in order, each only while tx_busy=0; then IDLE.
3. Invalid address: rx 8'h20 with NUM_REGS=16 -> one frame_err pulse, register_rdy never asserted.
4. Timeout: TIMEOUT_CYCLES=50; rx 8'h01, no second byte -> frame_err at cycle 50, IDLE. A following 8'h02, 8'h7E pair writes reg 2 = 7E.
5. Overrun: rx bytes during a dump and while register_ack is withheld -> rx_overrun pulse per byte; dump output and pending write unaffected.
6. Reset mid-dump: drop rst after 2 of 4 bytes sent -> all outputs 0 asynchronously. After release, a new 8'hFF re-dumps all 4 bytes from register 0.
